mem_port_arbiter: RTL and testbench
===================================

# mem_port_arbiter

Shares the single unified instruction/data memory port of the multi-cycle core between two requesters: the instruction fetch unit (IFU, read-only) and the load/store unit (LSU, read/write). It arbitrates round-robin and registers the winning request onto the memory port as a one-cycle enable pulse. It waits a fixed memory latency, captures read data, and returns a one-cycle response pulse to the owner. Address range and write-size checks are performed here, so out-of-range accesses never reach the memory.

## Interface
- MEM_LATENCY, 1: cycles from the issue pulse to valid `bMEM_iRdData`; legal values are ≥1.
- BASE_ADDR, 64'h80000000: first legal address.
- DEPTH, 4096: number of legal entries; an address is legal iff (addr − BASE_ADDR) < DEPTH, using unsigned 64-bit arithmetic.

Ports (clock and reset first):
- iClock  in  1  single clock; all logic is rising-edge.
- iReset  in  1  synchronous, active-high reset.
- bIFU_iReq  in  1  IFU read request; must be held, with its address stable, until `bIFU_oValid`.
- bIFU_iAddr  in  64  IFU fetch address.
- bIFU_oValid  out  1  one-cycle response pulse to the IFU.
- bIFU_oRdData  out  64  fetch data; valid only while `bIFU_oValid` is high.
- bIFU_oErr  out  1  high with `bIFU_oValid` when the address is out of range.
- bLSU_iRdEn  in  1  LSU load request; same hold rule as the IFU.
- bLSU_iWrEn  in  1  LSU store request; if both enables are high, the request is a store.
- bLSU_iAddr  in  64  LSU address.
- bLSU_iWrData  in  64  store data.
- bLSU_iWrByt  in  10  store size: 1, 2, 3 or 4 (byte, half, word, dword).
- bLSU_oValid  out  1  one-cycle response pulse to the LSU (load data or store acknowledge).
- bLSU_oRdData  out  64  load data; 0 for stores.
- bLSU_oErr  out  1  high with `bLSU_oValid` on an out-of-range address, or on a store size outside 1–4.
- bMEM_oRdEn  out  1  memory read enable; a one-cycle pulse.
- bMEM_oWrEn  out  1  memory write enable; a one-cycle pulse.
- bMEM_oAddr  out  64  registered address, passed through unmodified (the memory subtracts the base itself).
- bMEM_oWrData  out  64  registered store data.
- bMEM_oWrByt  out  10  registered store size.
- bMEM_iRdData  in  64  memory read data.
- oBusy  out  1  high in every state except IDLE.
- oGrant  out  2  one-hot owner of the current transaction: [0] = IFU, [1] = LSU; 0 when idle.

## Operation
- States: IDLE, ISSUE, WAIT, RESP.
- IDLE → ISSUE when any request is present. At that edge, latch the owner, address, write data, write size, read/write kind and the error flag.
- Arbitration uses round-robin on a `last` bit.
  - When both requesters request, the one not equal to `last` wins.
  - A single requester wins unconditionally.
  - `last` updates to the owner at each grant.
- ISSUE lasts 1 cycle.
  - Drive `bMEM_oRdEn` or `bMEM_oWrEn` high for exactly this cycle.
  - If the error flag is set, drive neither enable.
  - Go to WAIT.
- WAIT lasts MEM_LATENCY cycles, counted by a down-counter.
  - On the final WAIT cycle, capture `bMEM_iRdData` into the response register.
  - Writes and errored requests capture 0 instead.
  - Go to RESP.
- RESP lasts 1 cycle.
  - Pulse the owner's `oValid`, with `oErr` and `oRdData` alongside.
  - Arbitrate among pending requests, with the just-served requester's request masked.
  - Go to ISSUE if the other requester is requesting, otherwise to IDLE.
- Requester inputs are ignored after grant: changing them mid-transaction does not affect the transaction in flight.
- Store-size error: `bLSU_iWrEn` with `bLSU_iWrByt` not in 1–4 is errored; no write is performed.

## Timing
- Reset, applied synchronously in any state including mid-transaction:
  - state returns to IDLE; the in-flight transaction is dropped with no response, and requesters must reissue;
  - all outputs are 0;
  - `last` = LSU, so the IFU wins the first tie.
- Request sampled high at edge t (IDLE):
  - ISSUE during cycle t+1;
  - WAIT during cycles t+2 through t+1+MEM_LATENCY;
  - `oValid` during cycle t+2+MEM_LATENCY. With MEM_LATENCY=1, valid is 3 cycles after the request.
- Back-to-back service: with both requesting continuously, ISSUE pulses are spaced 2+MEM_LATENCY cycles apart and the owners alternate.
- The memory port outputs stay stable from ISSUE through RESP. Only the enables pulse.
- `oValid` is never high for both requesters in the same cycle. It is never high for more than 1 consecutive cycle per transaction.

## Test plan
- Single IFU read, addr=0x80000010, MEM_LATENCY=1, memory returns 0x00000013: `bMEM_oRdEn` pulses in cycle 1; `bIFU_oValid`=1 with data 0x13 in cycle 3; `oErr`=0.
- IFU and LSU load both requesting from reset: the IFU is served first, then the LSU. ISSUE pulses fall in cycles 1 and 4, valids in cycles 3 and 6, and `oGrant` goes 01 then 10.
- LSU store, addr=0x80000020, data 0xDEADBEEF, size 3: `bMEM_oWrEn` is high 1 cycle carrying that addr/data/size; `bLSU_oValid` rises with `oRdData`=0 and `oErr`=0.
- LSU load at addr=0x7FFFFFF8, and IFU read at 0x80000000+4096: no memory enable in either ISSUE cycle; `oValid` with `oErr`=1 and `oRdData`=0 for each.
- Store with size 7: no `bMEM_oWrEn`; `bLSU_oErr`=1 on the response.
- Reset asserted during WAIT of an LSU load: all outputs are 0 next cycle and the state is IDLE. With the LSU request still held, the load is reissued: ISSUE in the cycle after reset deasserts and a correct response follows 2 cycles later (MEM_LATENCY=1).

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing the unified memory port between the IFU and LSU.
// Owns range/size checking, issues one-cycle enables, and returns one-cycle responses.
module mem_port_arbiter #(
  parameter int unsigned MEM_LATENCY = 1,
  parameter logic [63:0] BASE_ADDR   = 64'h8000_0000,
  parameter int unsigned DEPTH       = 4096
) (
  input  logic        iClock,
  input  logic        iReset,
  input  logic        bIFU_iReq,
  input  logic [63:0] bIFU_iAddr,
  output logic        bIFU_oValid,
  output logic [63:0] bIFU_oRdData,
  output logic        bIFU_oErr,
  input  logic        bLSU_iRdEn,
  input  logic        bLSU_iWrEn,
  input  logic [63:0] bLSU_iAddr,
  input  logic [63:0] bLSU_iWrData,
  input  logic [9:0]  bLSU_iWrByt,
  output logic        bLSU_oValid,
  output logic [63:0] bLSU_oRdData,
  output logic        bLSU_oErr,
  output logic        bMEM_oRdEn,
  output logic        bMEM_oWrEn,
  output logic [63:0] bMEM_oAddr,
  output logic [63:0] bMEM_oWrData,
  output logic [9:0]  bMEM_oWrByt,
  input  logic [63:0] bMEM_iRdData,
  output logic        oBusy,
  output logic [1:0]  oGrant
);

  localparam int unsigned ADDR_W = 64;
  localparam int unsigned DATA_W = 64;
  localparam int unsigned BYT_W  = 10;
  localparam int unsigned CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic OWN_IFU = 1'b0;
  localparam logic OWN_LSU = 1'b1;

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

  state_t              state_q, state_d;
  logic                last_q, last_d;
  logic                owner_q, owner_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [DATA_W-1:0]   wr_data_q, wr_data_d;
  logic [BYT_W-1:0]    wr_byt_q, wr_byt_d;
  logic                is_wr_q, is_wr_d;
  logic                err_q, err_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic                rd_en_q, rd_en_d;
  logic                wr_en_q, wr_en_d;
  logic                ifu_valid_q, ifu_valid_d;
  logic                ifu_err_q, ifu_err_d;
  logic [DATA_W-1:0]   ifu_rd_data_q, ifu_rd_data_d;
  logic                lsu_valid_q, lsu_valid_d;
  logic                lsu_err_q, lsu_err_d;
  logic [DATA_W-1:0]   lsu_rd_data_q, lsu_rd_data_d;
  logic [1:0]          grant_q, grant_d;
  logic                busy_q;

  logic                cand_ifu, cand_lsu, win;
  logic [ADDR_W-1:0]   sel_addr;
  logic                sel_wr, sel_err, byt_bad, out_of_range;

  // Candidate requests; the requester just served is masked during RESP.
  always_comb begin
    cand_ifu     = bIFU_iReq & ~((state_q == RESP) && (owner_q == OWN_IFU));
    cand_lsu     = (bLSU_iRdEn | bLSU_iWrEn) & ~((state_q == RESP) && (owner_q == OWN_LSU));
    win          = (cand_ifu && cand_lsu) ? ~last_q : cand_lsu;
    sel_addr     = (win == OWN_LSU) ? bLSU_iAddr : bIFU_iAddr;
    sel_wr       = (win == OWN_LSU) && bLSU_iWrEn;
    byt_bad      = (bLSU_iWrByt < BYT_W'(1)) || (bLSU_iWrByt > BYT_W'(4));
    out_of_range = (sel_addr - BASE_ADDR) >= ADDR_W'(DEPTH);
    sel_err      = out_of_range || (sel_wr && byt_bad);
  end

  // Next-state and registered-output logic.
  always_comb begin
    state_d       = state_q;
    last_d        = last_q;
    owner_d       = owner_q;
    addr_d        = addr_q;
    wr_data_d     = wr_data_q;
    wr_byt_d      = wr_byt_q;
    is_wr_d       = is_wr_q;
    err_d         = err_q;
    cnt_d         = cnt_q;
    grant_d       = grant_q;
    rd_en_d       = 1'b0;
    wr_en_d       = 1'b0;
    ifu_valid_d   = 1'b0;
    ifu_err_d     = 1'b0;
    ifu_rd_data_d = '0;
    lsu_valid_d   = 1'b0;
    lsu_err_d     = 1'b0;
    lsu_rd_data_d = '0;

    case (state_q)
      IDLE: ;
      ISSUE: begin
        state_d = WAIT;
        cnt_d   = CNT_LOAD;
      end
      WAIT: begin
        if (cnt_q == '0) begin
          state_d = RESP;
          if (owner_q == OWN_IFU) begin
            ifu_valid_d   = 1'b1;
            ifu_err_d     = err_q;
            ifu_rd_data_d = (is_wr_q || err_q) ? '0 : bMEM_iRdData;
          end else begin
            lsu_valid_d   = 1'b1;
            lsu_err_d     = err_q;
            lsu_rd_data_d = (is_wr_q || err_q) ? '0 : bMEM_iRdData;
          end
        end else begin
          cnt_d = cnt_q - CNT_W'(1);
        end
      end
      RESP: begin
        state_d = IDLE;
        grant_d = 2'b00;
      end
      default: state_d = IDLE;
    endcase

    // Grant: latch the winning request so later input changes cannot disturb it.
    if (((state_q == IDLE) || (state_q == RESP)) && (cand_ifu || cand_lsu)) begin
      state_d   = ISSUE;
      owner_d   = win;
      last_d    = win;
      addr_d    = sel_addr;
      is_wr_d   = sel_wr;
      err_d     = sel_err;
      wr_data_d = sel_wr ? bLSU_iWrData : '0;
      wr_byt_d  = sel_wr ? bLSU_iWrByt : '0;
      rd_en_d   = ~sel_err & ~sel_wr;
      wr_en_d   = ~sel_err & sel_wr;
      grant_d   = (win == OWN_LSU) ? 2'b10 : 2'b01;
    end
  end

  always_ff @(posedge iClock) begin
    if (iReset) begin
      state_q       <= IDLE;
      last_q        <= OWN_LSU;
      owner_q       <= OWN_IFU;
      addr_q        <= '0;
      wr_data_q     <= '0;
      wr_byt_q      <= '0;
      is_wr_q       <= 1'b0;
      err_q         <= 1'b0;
      cnt_q         <= '0;
      grant_q       <= 2'b00;
      rd_en_q       <= 1'b0;
      wr_en_q       <= 1'b0;
      ifu_valid_q   <= 1'b0;
      ifu_err_q     <= 1'b0;
      ifu_rd_data_q <= '0;
      lsu_valid_q   <= 1'b0;
      lsu_err_q     <= 1'b0;
      lsu_rd_data_q <= '0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      last_q        <= last_d;
      owner_q       <= owner_d;
      addr_q        <= addr_d;
      wr_data_q     <= wr_data_d;
      wr_byt_q      <= wr_byt_d;
      is_wr_q       <= is_wr_d;
      err_q         <= err_d;
      cnt_q         <= cnt_d;
      grant_q       <= grant_d;
      rd_en_q       <= rd_en_d;
      wr_en_q       <= wr_en_d;
      ifu_valid_q   <= ifu_valid_d;
      ifu_err_q     <= ifu_err_d;
      ifu_rd_data_q <= ifu_rd_data_d;
      lsu_valid_q   <= lsu_valid_d;
      lsu_err_q     <= lsu_err_d;
      lsu_rd_data_q <= lsu_rd_data_d;
      busy_q        <= (state_d != IDLE);
    end
  end

  assign bIFU_oValid  = ifu_valid_q;
  assign bIFU_oRdData = ifu_rd_data_q;
  assign bIFU_oErr    = ifu_err_q;
  assign bLSU_oValid  = lsu_valid_q;
  assign bLSU_oRdData = lsu_rd_data_q;
  assign bLSU_oErr    = lsu_err_q;
  assign bMEM_oRdEn   = rd_en_q;
  assign bMEM_oWrEn   = wr_en_q;
  assign bMEM_oAddr   = addr_q;
  assign bMEM_oWrData = wr_data_q;
  assign bMEM_oWrByt  = wr_byt_q;
  assign oBusy        = busy_q;
  assign oGrant       = grant_q;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with MEM_LATENCY=1.
// The memory model returns addr - 0x7FFFFFFD one cycle after a read enable, garbage otherwise.
module tb_mem_port_arbiter;

  logic        iClock;
  logic        iReset;
  logic        bIFU_iReq;
  logic [63:0] bIFU_iAddr;
  logic        bIFU_oValid;
  logic [63:0] bIFU_oRdData;
  logic        bIFU_oErr;
  logic        bLSU_iRdEn;
  logic        bLSU_iWrEn;
  logic [63:0] bLSU_iAddr;
  logic [63:0] bLSU_iWrData;
  logic [9:0]  bLSU_iWrByt;
  logic        bLSU_oValid;
  logic [63:0] bLSU_oRdData;
  logic        bLSU_oErr;
  logic        bMEM_oRdEn;
  logic        bMEM_oWrEn;
  logic [63:0] bMEM_oAddr;
  logic [63:0] bMEM_oWrData;
  logic [9:0]  bMEM_oWrByt;
  logic [63:0] bMEM_iRdData;
  logic        oBusy;
  logic [1:0]  oGrant;

  int checks   = 0;
  int failures = 0;

  mem_port_arbiter dut (
    .iClock       (iClock),
    .iReset       (iReset),
    .bIFU_iReq    (bIFU_iReq),
    .bIFU_iAddr   (bIFU_iAddr),
    .bIFU_oValid  (bIFU_oValid),
    .bIFU_oRdData (bIFU_oRdData),
    .bIFU_oErr    (bIFU_oErr),
    .bLSU_iRdEn   (bLSU_iRdEn),
    .bLSU_iWrEn   (bLSU_iWrEn),
    .bLSU_iAddr   (bLSU_iAddr),
    .bLSU_iWrData (bLSU_iWrData),
    .bLSU_iWrByt  (bLSU_iWrByt),
    .bLSU_oValid  (bLSU_oValid),
    .bLSU_oRdData (bLSU_oRdData),
    .bLSU_oErr    (bLSU_oErr),
    .bMEM_oRdEn   (bMEM_oRdEn),
    .bMEM_oWrEn   (bMEM_oWrEn),
    .bMEM_oAddr   (bMEM_oAddr),
    .bMEM_oWrData (bMEM_oWrData),
    .bMEM_oWrByt  (bMEM_oWrByt),
    .bMEM_iRdData (bMEM_iRdData),
    .oBusy        (oBusy),
    .oGrant       (oGrant)
  );

  initial iClock = 1'b0;
  always #5 iClock = ~iClock;

  // Memory with one cycle of read latency.
  always @(posedge iClock) begin
    if (bMEM_oRdEn) bMEM_iRdData <= bMEM_oAddr - 64'h7FFF_FFFD;
    else            bMEM_iRdData <= 64'hBADB_ADBA_DBAD_BADB;
  end

  task automatic tick();
    @(posedge iClock);
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic chk_idle(input string tag);
    chk({tag, "_busy"},  64'(oBusy), 64'd0);
    chk({tag, "_grant"}, 64'(oGrant), 64'd0);
    chk({tag, "_ivld"},  64'(bIFU_oValid), 64'd0);
    chk({tag, "_lvld"},  64'(bLSU_oValid), 64'd0);
  endtask

  initial begin
    iReset       = 1'b1;
    bIFU_iReq    = 1'b0;
    bIFU_iAddr   = '0;
    bLSU_iRdEn   = 1'b0;
    bLSU_iWrEn   = 1'b0;
    bLSU_iAddr   = '0;
    bLSU_iWrData = '0;
    bLSU_iWrByt  = '0;
    tick();
    tick();

    // Reset state
    chk_idle("rst");
    chk("rst_rden",  64'(bMEM_oRdEn), 64'd0);
    chk("rst_wren",  64'(bMEM_oWrEn), 64'd0);
    chk("rst_addr",  bMEM_oAddr, 64'd0);
    chk("rst_idata", bIFU_oRdData, 64'd0);

    // Single IFU read
    iReset = 1'b0;
    bIFU_iReq = 1'b1; bIFU_iAddr = 64'h8000_0010;
    tick();
    chk("t1_rden_c1",  64'(bMEM_oRdEn), 64'd1);
    chk("t1_wren_c1",  64'(bMEM_oWrEn), 64'd0);
    chk("t1_addr_c1",  bMEM_oAddr, 64'h8000_0010);
    chk("t1_grant_c1", 64'(oGrant), 64'd1);
    chk("t1_busy_c1",  64'(oBusy), 64'd1);
    tick();
    chk("t1_rden_c2",  64'(bMEM_oRdEn), 64'd0);
    chk("t1_ivld_c2",  64'(bIFU_oValid), 64'd0);
    tick();
    chk("t1_ivld_c3",  64'(bIFU_oValid), 64'd1);
    chk("t1_idata_c3", bIFU_oRdData, 64'h13);
    chk("t1_ierr_c3",  64'(bIFU_oErr), 64'd0);
    chk("t1_lvld_c3",  64'(bLSU_oValid), 64'd0);
    bIFU_iReq = 1'b0;
    tick();
    chk_idle("t1_c4");

    // Both requesting from reset: IFU first, then LSU
    iReset = 1'b1;
    tick();
    iReset = 1'b0;
    bIFU_iReq = 1'b1; bIFU_iAddr = 64'h8000_0040;
    bLSU_iRdEn = 1'b1; bLSU_iAddr = 64'h8000_0100;
    tick();
    chk("t2_rden_c1",  64'(bMEM_oRdEn), 64'd1);
    chk("t2_addr_c1",  bMEM_oAddr, 64'h8000_0040);
    chk("t2_grant_c1", 64'(oGrant), 64'b01);
    tick();
    chk("t2_rden_c2",  64'(bMEM_oRdEn), 64'd0);
    tick();
    chk("t2_ivld_c3",  64'(bIFU_oValid), 64'd1);
    chk("t2_idata_c3", bIFU_oRdData, 64'h43);
    chk("t2_lvld_c3",  64'(bLSU_oValid), 64'd0);
    bIFU_iReq = 1'b0;
    tick();
    chk("t2_rden_c4",  64'(bMEM_oRdEn), 64'd1);
    chk("t2_addr_c4",  bMEM_oAddr, 64'h8000_0100);
    chk("t2_grant_c4", 64'(oGrant), 64'b10);
    chk("t2_ivld_c4",  64'(bIFU_oValid), 64'd0);
    tick();
    chk("t2_lvld_c5",  64'(bLSU_oValid), 64'd0);
    tick();
    chk("t2_lvld_c6",  64'(bLSU_oValid), 64'd1);
    chk("t2_ldata_c6", bLSU_oRdData, 64'h103);
    chk("t2_lerr_c6",  64'(bLSU_oErr), 64'd0);
    chk("t2_ivld_c6",  64'(bIFU_oValid), 64'd0);
    bLSU_iRdEn = 1'b0;
    tick();
    chk_idle("t2_c7");

    // LSU store; inputs change after grant and must not leak through
    bLSU_iWrEn = 1'b1; bLSU_iAddr = 64'h8000_0020;
    bLSU_iWrData = 64'hDEAD_BEEF; bLSU_iWrByt = 10'd3;
    tick();
    chk("t3_wren_c1",  64'(bMEM_oWrEn), 64'd1);
    chk("t3_rden_c1",  64'(bMEM_oRdEn), 64'd0);
    chk("t3_addr_c1",  bMEM_oAddr, 64'h8000_0020);
    chk("t3_wdata_c1", bMEM_oWrData, 64'hDEAD_BEEF);
    chk("t3_wbyt_c1",  64'(bMEM_oWrByt), 64'd3);
    chk("t3_grant_c1", 64'(oGrant), 64'b10);
    bLSU_iAddr = 64'h8000_0777; bLSU_iWrData = 64'h1234;
    tick();
    chk("t3_wren_c2",  64'(bMEM_oWrEn), 64'd0);
    chk("t3_addr_c2",  bMEM_oAddr, 64'h8000_0020);
    chk("t3_wdata_c2", bMEM_oWrData, 64'hDEAD_BEEF);
    tick();
    chk("t3_lvld_c3",  64'(bLSU_oValid), 64'd1);
    chk("t3_ldata_c3", bLSU_oRdData, 64'd0);
    chk("t3_lerr_c3",  64'(bLSU_oErr), 64'd0);
    chk("t3_addr_c3",  bMEM_oAddr, 64'h8000_0020);
    bLSU_iWrEn = 1'b0;
    tick();
    chk_idle("t3_c4");

    // LSU load below base
    bLSU_iRdEn = 1'b1; bLSU_iAddr = 64'h7FFF_FFF8;
    tick();
    chk("t4a_rden_c1",  64'(bMEM_oRdEn), 64'd0);
    chk("t4a_wren_c1",  64'(bMEM_oWrEn), 64'd0);
    chk("t4a_busy_c1",  64'(oBusy), 64'd1);
    tick();
    tick();
    chk("t4a_lvld_c3",  64'(bLSU_oValid), 64'd1);
    chk("t4a_lerr_c3",  64'(bLSU_oErr), 64'd1);
    chk("t4a_ldata_c3", bLSU_oRdData, 64'd0);
    bLSU_iRdEn = 1'b0;
    tick();

    // IFU read one past the end
    bIFU_iReq = 1'b1; bIFU_iAddr = 64'h8000_1000;
    tick();
    chk("t4b_rden_c1",  64'(bMEM_oRdEn), 64'd0);
    chk("t4b_grant_c1", 64'(oGrant), 64'b01);
    tick();
    tick();
    chk("t4b_ivld_c3",  64'(bIFU_oValid), 64'd1);
    chk("t4b_ierr_c3",  64'(bIFU_oErr), 64'd1);
    chk("t4b_idata_c3", bIFU_oRdData, 64'd0);
    bIFU_iReq = 1'b0;
    tick();

    // IFU read at the last legal address
    bIFU_iReq = 1'b1; bIFU_iAddr = 64'h8000_0FFF;
    tick();
    chk("t4c_rden_c1",  64'(bMEM_oRdEn), 64'd1);
    tick();
    tick();
    chk("t4c_ivld_c3",  64'(bIFU_oValid), 64'd1);
    chk("t4c_ierr_c3",  64'(bIFU_oErr), 64'd0);
    chk("t4c_idata_c3", bIFU_oRdData, 64'h1002);
    bIFU_iReq = 1'b0;
    tick();

    // Store with illegal size
    bLSU_iWrEn = 1'b1; bLSU_iAddr = 64'h8000_0020;
    bLSU_iWrData = 64'h55; bLSU_iWrByt = 10'd7;
    tick();
    chk("t5_wren_c1",  64'(bMEM_oWrEn), 64'd0);
    chk("t5_rden_c1",  64'(bMEM_oRdEn), 64'd0);
    tick();
    tick();
    chk("t5_lvld_c3",  64'(bLSU_oValid), 64'd1);
    chk("t5_lerr_c3",  64'(bLSU_oErr), 64'd1);
    chk("t5_ldata_c3", bLSU_oRdData, 64'd0);
    bLSU_iWrEn = 1'b0;
    tick();

    // Reset during WAIT of an LSU load, request held so it reissues
    bLSU_iRdEn = 1'b1; bLSU_iAddr = 64'h8000_0200;
    tick();
    chk("t6_rden_c1",  64'(bMEM_oRdEn), 64'd1);
    tick();
    iReset = 1'b1;
    tick();
    chk_idle("t6_rst");
    chk("t6_rst_rden", 64'(bMEM_oRdEn), 64'd0);
    chk("t6_rst_addr", bMEM_oAddr, 64'd0);
    chk("t6_rst_ldata", bLSU_oRdData, 64'd0);
    iReset = 1'b0;
    tick();
    chk("t6_rden_re",  64'(bMEM_oRdEn), 64'd1);
    chk("t6_addr_re",  bMEM_oAddr, 64'h8000_0200);
    chk("t6_grant_re", 64'(oGrant), 64'b10);
    tick();
    chk("t6_lvld_w",   64'(bLSU_oValid), 64'd0);
    tick();
    chk("t6_lvld_r",   64'(bLSU_oValid), 64'd1);
    chk("t6_ldata_r",  bLSU_oRdData, 64'h203);
    chk("t6_lerr_r",   64'(bLSU_oErr), 64'd0);
    bLSU_iRdEn = 1'b0;
    tick();
    chk_idle("t6_end");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
